// File: rtl/rf_pkg.sv
// ---------------------------------------------------------------------------
// rf_pkg
// Shared register-file writeback definitions: default widths, writeback
// source IDs, the writeback request type and a small index helper.
// Ports: none (package).
// ---------------------------------------------------------------------------
package rf_pkg;

   localparam int unsigned XLEN       = 32;
   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned NUM_WB_SRC = 3;

   // Writeback source IDs (index into the arbiter's request vector)
   localparam int unsigned WB_SRC_ALU = 0;
   localparam int unsigned WB_SRC_LSU = 1;
   localparam int unsigned WB_SRC_MUL = 2;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] addr;
      logic [XLEN-1:0]       data;
   } wb_req_t;

   // Next index after idx, wrapping modulo n
   function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter: the search starts at i_ptr and wraps
// modulo NUM_REQ; the first set request wins.
// Ports:
//   i_req  NUM_REQ  request vector
//   i_ptr  PTR_W    index where the search starts (must be < NUM_REQ)
//   o_gnt  NUM_REQ  one-hot grant, all-zero when no request is set
// ---------------------------------------------------------------------------
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 3,
   parameter int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [PTR_W-1:0]   i_ptr,
   output logic [NUM_REQ-1:0] o_gnt
);

   logic        w_found;
   int unsigned w_idx;

   always_comb begin
      o_gnt   = '0;
      w_found = 1'b0;
      w_idx   = 0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         w_idx = (32'(i_ptr) + k) % NUM_REQ;
         if (!w_found && i_req[w_idx]) begin
            o_gnt[w_idx] = 1'b1;
            w_found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// rf_wb_arbiter
// Shares the register file's single write port among NUM_SRC writeback
// sources. One valid/ready handshake per cycle at most; the winner's request
// is registered and driven to the register file one cycle later. Writes to
// x0 complete their handshake but never raise o_rf_reg_write.
//
// Build option: define WB_FIXED_PRIO_EN for fixed priority (lowest index
// wins, no round-robin pointer); undefined gives round-robin arbitration.
//
// Ports:
//   clk              clock
//   reset            asynchronous, active-high reset
//   i_hold           freeze arbitration, no grants while high
//   i_src_valid      per-source write request
//   o_src_ready      per-source grant (combinational, one-hot or zero)
//   i_src_addr       packed destination indices, source i at [i*REG_ADDR_W +: REG_ADDR_W]
//   i_src_data       packed write data, same packing
//   o_rf_reg_write   register-file write enable
//   o_rf_write_reg   register-file destination index
//   o_rf_write_data  register-file write data
//   o_grant_id       source that produced the current rf_* write
//   o_conflict       registered: >1 source valid last cycle with hold low
// ---------------------------------------------------------------------------
module rf_wb_arbiter #(
   parameter int unsigned NUM_SRC    = rf_pkg::NUM_WB_SRC,
   parameter int unsigned XLEN       = rf_pkg::XLEN,
   parameter int unsigned REG_ADDR_W = rf_pkg::REG_ADDR_W,
   parameter int unsigned ID_W       = $clog2(NUM_SRC)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         i_hold,
   input  logic [NUM_SRC-1:0]           i_src_valid,
   output logic [NUM_SRC-1:0]           o_src_ready,
   input  logic [NUM_SRC*REG_ADDR_W-1:0] i_src_addr,
   input  logic [NUM_SRC*XLEN-1:0]      i_src_data,
   output logic                         o_rf_reg_write,
   output logic [REG_ADDR_W-1:0]        o_rf_write_reg,
   output logic [XLEN-1:0]              o_rf_write_data,
   output logic [ID_W-1:0]              o_grant_id,
   output logic                         o_conflict
);

   import rf_pkg::*;

   logic [NUM_SRC-1:0]    w_req;
   logic [NUM_SRC-1:0]    w_gnt;
   logic                  w_hs;
   logic [ID_W-1:0]       w_win;
   logic [REG_ADDR_W-1:0] w_win_addr;
   logic [XLEN-1:0]       w_win_data;

   logic                  r_reg_write;
   logic [REG_ADDR_W-1:0] r_write_reg;
   logic [XLEN-1:0]       r_write_data;
   logic [ID_W-1:0]       r_grant_id;
   logic                  r_conflict;

   // No grants while held or while reset is asserted
   assign w_req = (reset || i_hold) ? '0 : i_src_valid;

`ifdef WB_FIXED_PRIO_EN
   // Isolate the lowest set bit
   assign w_gnt = w_req & (~w_req + NUM_SRC'(1));
`else
   logic [ID_W-1:0] r_rr_ptr;

   rr_arbiter #(
      .NUM_REQ (NUM_SRC),
      .PTR_W   (ID_W)
   ) u_rr_arbiter (
      .i_req (w_req),
      .i_ptr (r_rr_ptr),
      .o_gnt (w_gnt)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rr_ptr <= '0;
      end else if (w_hs) begin
         r_rr_ptr <= ID_W'(wrap_inc(32'(w_win), NUM_SRC));
      end
   end
`endif

   assign o_src_ready = w_gnt;
   assign w_hs        = |w_gnt;

   always_comb begin
      w_win = '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         if (w_gnt[i]) w_win = ID_W'(i);
      end
   end

   assign w_win_addr = i_src_addr[w_win*REG_ADDR_W +: REG_ADDR_W];
   assign w_win_data = i_src_data[w_win*XLEN +: XLEN];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_reg_write  <= 1'b0;
         r_write_reg  <= '0;
         r_write_data <= '0;
         r_grant_id   <= '0;
         r_conflict   <= 1'b0;
      end else begin
         // x0 writes complete the handshake but are dropped here
         r_reg_write <= w_hs && (w_win_addr != '0);
         if (w_hs) begin
            r_write_reg  <= w_win_addr;
            r_write_data <= w_win_data;
            r_grant_id   <= w_win;
         end
         // v & (v-1) is nonzero iff more than one bit is set
         r_conflict <= ((i_src_valid & (i_src_valid - NUM_SRC'(1))) != '0) && !i_hold;
      end
   end

   assign o_rf_reg_write  = r_reg_write;
   assign o_rf_write_reg  = r_write_reg;
   assign o_rf_write_data = r_write_data;
   assign o_grant_id      = r_grant_id;
   assign o_conflict      = r_conflict;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rf_wb_arbiter
// Directed self-checking bench for rf_wb_arbiter (default round-robin build).
// A small register-file model records writes driven by the DUT.
// ---------------------------------------------------------------------------
module tb_rf_wb_arbiter;

   localparam int unsigned NS = 3;
   localparam int unsigned AW = 5;
   localparam int unsigned DW = 32;

   logic            clk = 1'b0;
   logic            reset;
   logic            hold;
   logic [NS-1:0]   src_valid;
   logic [NS-1:0]   src_ready;
   logic [NS*AW-1:0] src_addr;
   logic [NS*DW-1:0] src_data;
   logic            rf_reg_write;
   logic [AW-1:0]   rf_write_reg;
   logic [DW-1:0]   rf_write_data;
   logic [1:0]      grant_id;
   logic            conflict;

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] rf [32] = '{default: '0};

   always #5 clk = ~clk;

   rf_wb_arbiter #(
      .NUM_SRC    (NS),
      .XLEN       (DW),
      .REG_ADDR_W (AW)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .i_hold          (hold),
      .i_src_valid     (src_valid),
      .o_src_ready     (src_ready),
      .i_src_addr      (src_addr),
      .i_src_data      (src_data),
      .o_rf_reg_write  (rf_reg_write),
      .o_rf_write_reg  (rf_write_reg),
      .o_rf_write_data (rf_write_data),
      .o_grant_id      (grant_id),
      .o_conflict      (conflict)
   );

   // Register-file model: commits on the edge after rf_reg_write is seen
   always @(posedge clk) begin
      if (rf_reg_write) rf[rf_write_reg] <= rf_write_data;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_src(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
      src_addr[i*AW +: AW] = a;
      src_data[i*DW +: DW] = d;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1;
   endtask

   initial begin
      reset     = 1'b1;
      hold      = 1'b0;
      src_valid = '1;
      src_addr  = '0;
      src_data  = '0;
      #2;
      chk("rst_ready", 64'(src_ready), 64'h0);
      step();
      chk("rst_we", 64'(rf_reg_write), 64'h0);
      chk("rst_reg", 64'(rf_write_reg), 64'h0);
      chk("rst_data", 64'(rf_write_data), 64'h0);
      chk("rst_gid", 64'(grant_id), 64'h0);
      chk("rst_conf", 64'(conflict), 64'h0);
      src_valid = '0;
      reset     = 1'b0;

      // Single source
      step();
      set_src(0, 5'd5, 32'hDEADBEEF);
      src_valid = 3'b001;
      #1;
      chk("single_ready", 64'(src_ready), 64'h1);
      step();
      src_valid = '0;
      chk("single_we", 64'(rf_reg_write), 64'h1);
      chk("single_reg", 64'(rf_write_reg), 64'h5);
      chk("single_data", 64'(rf_write_data), 64'hDEADBEEF);
      chk("single_gid", 64'(grant_id), 64'h0);
      chk("single_conf", 64'(conflict), 64'h0);
      step();
      chk("single_we_drop", 64'(rf_reg_write), 64'h0);

      // Round-robin from rr_ptr=0
      do_reset();
      set_src(0, 5'd1, 32'hA0);
      set_src(1, 5'd2, 32'hA1);
      set_src(2, 5'd3, 32'hA2);
      src_valid = 3'b111;
      for (int k = 0; k < 6; k++) begin
         #1;
         chk("rr_ready", 64'(src_ready), 64'(1 << (k % 3)));
         step();
         chk("rr_gid", 64'(grant_id), 64'(k % 3));
         chk("rr_reg", 64'(rf_write_reg), 64'(k % 3 + 1));
         chk("rr_we", 64'(rf_reg_write), 64'h1);
         chk("rr_conf", 64'(conflict), 64'h1);
      end
      src_valid = '0;
      step();
      chk("rr_idle_we", 64'(rf_reg_write), 64'h0);
      chk("rr_idle_conf", 64'(conflict), 64'h0);

      // x0 drop (rr_ptr=0)
      set_src(1, 5'd0, 32'h55);
      src_valid = 3'b010;
      #1;
      chk("x0_ready", 64'(src_ready), 64'h2);
      step();
      chk("x0_we", 64'(rf_reg_write), 64'h0);
      chk("x0_gid", 64'(grant_id), 64'h1);

      // Same-address ordering (rr_ptr=2)
      set_src(0, 5'd7, 32'd11);
      set_src(2, 5'd7, 32'd22);
      src_valid = 3'b101;
      #1;
      chk("same_ready_a", 64'(src_ready), 64'h4);
      step();
      src_valid = 3'b001;
      chk("same_data_a", 64'(rf_write_data), 64'd22);
      chk("same_gid_a", 64'(grant_id), 64'h2);
      #1;
      chk("same_ready_b", 64'(src_ready), 64'h1);
      step();
      src_valid = '0;
      chk("same_data_b", 64'(rf_write_data), 64'd11);
      chk("same_gid_b", 64'(grant_id), 64'h0);
      step();
      step();
      chk("rf_x7", 64'(rf[7]), 64'd11);
      chk("rf_x0", 64'(rf[0]), 64'h0);

      // hold (rr_ptr=1)
      set_src(0, 5'd1, 32'hB0);
      set_src(1, 5'd2, 32'hB1);
      set_src(2, 5'd3, 32'hB2);
      src_valid = 3'b111;
      #1;
      chk("hold_pre_ready", 64'(src_ready), 64'h2);
      step();
      hold = 1'b1;
      #1;
      chk("hold_ready0", 64'(src_ready), 64'h0);
      chk("hold_inflight_we", 64'(rf_reg_write), 64'h1);
      for (int k = 0; k < 3; k++) begin
         step();
         chk("hold_ready", 64'(src_ready), 64'h0);
         chk("hold_we", 64'(rf_reg_write), 64'h0);
         chk("hold_conf", 64'(conflict), 64'h0);
      end
      hold = 1'b0;
      #1;
      chk("hold_resume_ready", 64'(src_ready), 64'h4);
      step();
      chk("hold_resume_gid", 64'(grant_id), 64'h2);
      chk("hold_resume_we", 64'(rf_reg_write), 64'h1);

      // Reset mid-write (rr_ptr=0 -> grant 1 -> rr_ptr=2, then reset)
      src_valid = 3'b010;
      #1;
      chk("mid_ready", 64'(src_ready), 64'h2);
      step();
      src_valid = '0;
      chk("mid_we_pre", 64'(rf_reg_write), 64'h1);
      #1;
      reset = 1'b1;
      #1;
      chk("mid_we_async", 64'(rf_reg_write), 64'h0);
      chk("mid_reg_async", 64'(rf_write_reg), 64'h0);
      chk("mid_data_async", 64'(rf_write_data), 64'h0);
      step();
      reset = 1'b0;
      src_valid = 3'b111;
      #1;
      chk("mid_post_ready", 64'(src_ready), 64'h1);
      step();
      src_valid = '0;
      chk("mid_post_gid", 64'(grant_id), 64'h0);
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port among NUM_SRC writeback sources (ALU, load unit, mul/div unit).
- Round-robin arbitration over valid/ready handshakes; at most one write issued per cycle.
- The winning request is registered and presented to the register file as reg_write/write_reg/write_data.
- Sits between the execute/memory writeback sources and register_file. Writes to x0 are accepted but dropped here.

Parameters:
- NUM_SRC, 3, number of writeback requesters (2..8).
- XLEN, 32, data width.
- REG_ADDR_W, 5, register index width.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high.
- hold  input  1  freeze arbitration (pipeline halt/debug); no grants while high.
- src_valid  input  NUM_SRC  per-source write request.
- src_ready  output  NUM_SRC  per-source grant; handshake completes when valid&ready.
- src_addr  input  NUM_SRC*REG_ADDR_W  packed destination indices; source i occupies bits [i*REG_ADDR_W +: REG_ADDR_W].
- src_data  input  NUM_SRC*XLEN  packed write data, same packing.
- rf_reg_write  output  1  write enable to register file.
- rf_write_reg  output  REG_ADDR_W  destination index.
- rf_write_data  output  XLEN  write data.
- grant_id  output  $clog2(NUM_SRC)  index of the source that produced the current rf_* write.
- conflict  output  1  registered pulse: more than one source was valid in the previous cycle with hold low.

Behaviour:
- Reset (async, active-high): rf_reg_write=0, rf_write_reg=0, rf_write_data=0, grant_id=0, conflict=0, rr_ptr=0. src_ready is combinational and is 0 while reset is high.
- Arbitration (combinational): the search starts at rr_ptr and wraps modulo NUM_SRC. The first valid source wins.
- src_ready is one-hot at the winner, or all-zero if no source is valid or hold=1.
- src_ready depends on src_valid. Sources must not make src_valid depend on src_ready.
- Once asserted, src_valid, src_addr and src_data stay stable until the handshake completes.
- rr_ptr: on a handshake by source w, rr_ptr <= (w+1) mod NUM_SRC. Otherwise rr_ptr holds.
- Output stage, next posedge after a handshake by source w:
  - rf_write_reg <= src_addr[w]; rf_write_data <= src_data[w]; grant_id <= w.
  - rf_reg_write <= (src_addr[w] != 0).
- Output stage, any cycle with no handshake: rf_reg_write <= 0. rf_write_reg, rf_write_data and grant_id hold their values.
- Latency:
  - Handshake at edge N: rf_reg_write is high during cycle N+1.
  - The register file commits the write at edge N+2.
  - rf_reg_write is high for exactly one cycle per accepted request; throughput is 1 write/cycle.
- x0 target: handshake completes, rr_ptr advances, rf_reg_write stays 0 (dropped, but counts as a turn).
- Same-address requests from two sources in one cycle: only the winner is granted. The loser is granted in a later cycle, so its write lands last (grant order = commit order).
- hold=1: no handshakes, src_ready=0, rr_ptr frozen. rf_reg_write drops to 0 on the next edge; an in-flight output cycle still completes.
- conflict <= (popcount(src_valid) > 1) && !hold, each cycle.
- Reset mid-operation: a pending registered write is discarded (rf_reg_write=0 immediately). Un-granted requests are not remembered.

Optional Feature:
- Macro WB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins. rr_ptr is removed and its logic not generated. Starvation of high indices is permitted.
- Undefined: round-robin as specified above.

Decomposition:
- Package rf_pkg holds:
  - XLEN=32, REG_ADDR_W=5, NUM_WB_SRC=3.
  - Source ID constants: WB_SRC_ALU=0, WB_SRC_LSU=1, WB_SRC_MUL=2.
  - typedef wb_req_t {addr, data}.
- One sub-module, rr_arbiter (NUM_REQ parameter): request vector + pointer in, one-hot grant out. It is bypassed by WB_FIXED_PRIO_EN.
- Output register and x0 filtering stay in rf_wb_arbiter.

Test Plan:
- Single source: after reset, src_valid=001, addr=5, data=32'hDEADBEEF -> src_ready=001 same cycle; next cycle rf_reg_write=1, rf_write_reg=5, rf_write_data=DEADBEEF, grant_id=0; one cycle later rf_reg_write=0.
- Round-robin: all three valid continuously from rr_ptr=0 for 6 cycles -> grant order 0,1,2,0,1,2; conflict=1 each following cycle; no source waits more than 2 cycles.
- x0 drop: source 1 valid with addr=0 -> src_ready[1]=1, rr_ptr->2, rf_reg_write stays 0; the register file reads x0=0.
- Same-address ordering: sources 0 and 2 both target x7 (data 11, 22), rr_ptr=2 -> src2 wins first, src0 next; final x7=11.
- hold: hold=1 for 3 cycles with all sources valid -> src_ready=000 and rf_reg_write=0 from the cycle after hold rises; on release the grant resumes at the frozen rr_ptr.
- Reset mid-write: assert reset during the cycle rf_reg_write=1 -> rf_reg_write falls asynchronously to 0; after release rr_ptr=0 and source 0 has priority.
- With WB_FIXED_PRIO_EN: all valid -> source 0 is granted every cycle.
